// File: rtl/jk_reg_counter_if.sv
// Control/data bundle for jk_reg_counter: the master drives the update controls and
// J/K/D data, and the slave returns the register state and status pulses.
interface jk_reg_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;
    logic             changed;

    modport master (
        output en, mode, j, k, d,
        input  q, qn, tc, changed
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, qn, tc, changed
    );
endinterface

// File: rtl/jk_reg_counter.sv
// WIDTH-bit JK register bank with parallel load and up/down count modes.
// Defining JKREG_SATURATE_EN makes the count modes saturate instead of wrapping.
module jk_reg_counter #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic          clk,
    input logic          rst,
    jk_reg_counter_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             changed_r;
    logic [WIDTH-1:0] next_q_c;
    logic             wrap_c;
    mode_e            mode_c;

    assign mode_c = mode_e'(bus.mode);

    // Next state; j/k/d are only read inside their own mode branch so ignored inputs never reach q
    always_comb begin
        next_q_c = q_r;
        wrap_c   = 1'b0;
        if (bus.en) begin
            unique case (mode_c)
                MODE_JK: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        unique case ({bus.j[i], bus.k[i]})
                            2'b00:   next_q_c[i] = q_r[i];
                            2'b01:   next_q_c[i] = 1'b0;
                            2'b10:   next_q_c[i] = 1'b1;
                            default: next_q_c[i] = ~q_r[i];
                        endcase
                    end
                end
                MODE_LOAD: next_q_c = bus.d;
                MODE_UP: begin
                    wrap_c = (q_r == ALL_ONES);
`ifdef JKREG_SATURATE_EN
                    next_q_c = wrap_c ? ALL_ONES : q_r + WIDTH'(1);
`else
                    next_q_c = q_r + WIDTH'(1);
`endif
                end
                default: begin
                    wrap_c = (q_r == ALL_ZERO);
`ifdef JKREG_SATURATE_EN
                    next_q_c = wrap_c ? ALL_ZERO : q_r - WIDTH'(1);
`else
                    next_q_c = q_r - WIDTH'(1);
`endif
                end
            endcase
        end
    end

    // State and status registers; reset discards any pending wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= RESET_VAL;
            tc_r      <= 1'b0;
            changed_r <= 1'b0;
        end else begin
            q_r       <= next_q_c;
            tc_r      <= wrap_c;
            changed_r <= (next_q_c != q_r);
        end
    end

    assign bus.q       = q_r;
    assign bus.qn      = ~q_r;
    assign bus.tc      = tc_r;
    assign bus.changed = changed_r;
endmodule

// File: tb/tb_jk_reg_counter.sv
// Randomized self-checking bench for jk_reg_counter (WIDTH=4) against an arithmetic model,
// with directed sequences pinned to hand-computed values. Honours JKREG_SATURATE_EN.
module tb_jk_reg_counter;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    // Model state, in plain integers
    int   m_q;
    int   m_tc;
    int   m_ch;
    bit   m_valid = 1'b0;

    jk_reg_counter_if #(.WIDTH(W)) bus ();

    jk_reg_counter #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: JK characteristic equation and modular arithmetic
    always @(posedge clk) begin
        int nq;
        int wrap;
        if (rst) begin
            m_q = 0; m_tc = 0; m_ch = 0; m_valid = 1'b1;
        end else if (!bus.en) begin
            m_tc = 0; m_ch = 0;
        end else begin
            wrap = 0;
            case (int'(bus.mode))
                0: nq = ((int'(bus.j) & ~m_q) | (~int'(bus.k) & m_q)) & 15;
                1: nq = int'(bus.d);
                2: begin
                    wrap = (m_q == 15) ? 1 : 0;
`ifdef JKREG_SATURATE_EN
                    nq = wrap ? 15 : m_q + 1;
`else
                    nq = (m_q + 1) % 16;
`endif
                end
                default: begin
                    wrap = (m_q == 0) ? 1 : 0;
`ifdef JKREG_SATURATE_EN
                    nq = wrap ? 0 : m_q - 1;
`else
                    nq = (m_q + 15) % 16;
`endif
                end
            endcase
            m_ch = (nq != m_q) ? 1 : 0;
            m_tc = wrap;
            m_q  = nq;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_q", int'(bus.q), m_q);
            chk("cyc_qn", int'(bus.qn), (~m_q) & 15);
            chk("cyc_tc", int'(bus.tc), m_tc);
            chk("cyc_changed", int'(bus.changed), m_ch);
        end
    end

    task automatic cyc(input bit r, input bit e, input int md, input int jv, input int kv, input int dv);
        @(negedge clk);
        rst      = r;
        bus.en   = e;
        bus.mode = 2'(md);
        bus.j    = 4'(jv);
        bus.k    = 4'(kv);
        bus.d    = 4'(dv);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int eq, input int etc, input int ech);
        chk({name, "_q"}, int'(bus.q), eq);
        chk({name, "_tc"}, int'(bus.tc), etc);
        chk({name, "_changed"}, int'(bus.changed), ech);
    endtask

    initial begin
        rst = 1'b0; bus.en = 1'b0; bus.mode = 2'b00;
        bus.j = '0; bus.k = '0; bus.d = '0;

        // Reset overrides en and COUNT UP
        cyc(1, 1, 2, 0, 0, 0);
        lit("reset", 0, 0, 0);
        chk("reset_qn", int'(bus.qn), 15);

        // JK: set / clear / toggle / hold, then all-toggle
        cyc(0, 1, 0, 4'b1010, 4'b0110, 4'hF);
        lit("jk1", 4'b1010, 0, 1);
        cyc(0, 1, 0, 4'b1111, 4'b1111, 0);
        lit("jk2", 4'b0101, 0, 1);

        // Load then hold with en=0
        cyc(0, 1, 1, 4'hF, 4'hF, 4'b1001);
        lit("load", 4'b1001, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 4'hF);
        lit("hold", 4'b1001, 0, 0);

        // Count up across the top
        cyc(0, 1, 1, 0, 0, 4'b1110);
        cyc(0, 1, 2, 0, 0, 0);
        lit("up1", 15, 0, 1);
        cyc(0, 1, 2, 0, 0, 0);
`ifdef JKREG_SATURATE_EN
        lit("up2", 15, 1, 0);
        cyc(0, 1, 2, 0, 0, 0);
        lit("up3", 15, 1, 0);
`else
        lit("up2", 0, 1, 1);
        cyc(0, 1, 2, 0, 0, 0);
        lit("up3", 1, 0, 1);
`endif

        // Count down across zero
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 1, 3, 0, 0, 0);
        lit("dn1", 0, 0, 1);
        cyc(0, 1, 3, 0, 0, 0);
`ifdef JKREG_SATURATE_EN
        lit("dn2", 0, 1, 0);
`else
        lit("dn2", 15, 1, 1);
`endif

        // Reset in the middle of counting
        cyc(0, 1, 1, 0, 0, 5);
        cyc(0, 1, 2, 0, 0, 0);
        lit("mid1", 6, 0, 1);
        cyc(0, 1, 2, 0, 0, 0);
        lit("mid2", 7, 0, 1);
        cyc(1, 1, 2, 0, 0, 0);
        lit("mid_rst", 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0);
        lit("mid_resume", 1, 0, 1);

        // Randomized traffic; loads biased toward the wrap boundaries
        for (int n = 0; n < 3000; n++) begin
            int dv;
            dv = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) dv = ($urandom_range(0, 1) == 1) ? 15 : 0;
            cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), dv);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
